// File: rtl/alu_pkg.sv
// Shared constants, types and decode helper for the ALU issue/writeback controller.
package alu_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned OP_W       = 5;
  localparam int unsigned FUNCT_W    = 6;

  // ALU op codes presented on alu_op
  localparam logic [OP_W-1:0] A_NOP = 5'd0;
  localparam logic [OP_W-1:0] A_ADD = 5'd1;
  localparam logic [OP_W-1:0] A_SUB = 5'd2;
  localparam logic [OP_W-1:0] A_AND = 5'd3;
  localparam logic [OP_W-1:0] A_OR  = 5'd4;
  localparam logic [OP_W-1:0] A_XOR = 5'd5;
  localparam logic [OP_W-1:0] A_NOR = 5'd6;

  // MIPS R-type funct field values
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] F_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            illegal;
  } decode_t;

  // Map funct to ALU op; anything undecoded becomes NOP and is flagged illegal
  function automatic decode_t decode_funct(input logic [FUNCT_W-1:0] funct);
    decode_t d;
    d.op      = A_NOP;
    d.illegal = 1'b0;
    case (funct)
      F_ADD, F_ADDU: d.op = A_ADD;
      F_SUB, F_SUBU: d.op = A_SUB;
      F_AND:         d.op = A_AND;
      F_OR:          d.op = A_OR;
      F_XOR:         d.op = A_XOR;
      F_NOR:         d.op = A_NOR;
      default:       d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// Register file: three combinational read ports, one synchronous write port, r0 fixed at zero.
module regfile_32x32 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     rs_addr,
  output logic [DATA_W-1:0] rs_rdata,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rt_rdata,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  // Next array contents: single write, writes to r0 are dropped
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rs_rdata  = (rs_addr  == '0) ? '0 : mem_q[rs_addr];
  assign rt_rdata  = (rt_addr  == '0) ? '0 : mem_q[rt_addr];
  assign dbg_rdata = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving an external combinational ALU from an internal register file.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [FUNCT_W-1:0] instr_funct,
  input  logic [AW-1:0]      instr_rs,
  input  logic [AW-1:0]      instr_rt,
  input  logic [AW-1:0]      instr_rd,
  input  logic               init_we,
  input  logic [AW-1:0]      init_addr,
  input  logic [DATA_W-1:0]  init_wdata,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               done,
  output logic [AW-1:0]      done_rd,
  output logic [DATA_W-1:0]  done_result,
  output logic               illegal,
  input  logic [AW-1:0]      dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              ill_q, ill_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [AW-1:0]     done_rd_q, done_rd_d;
  logic [DATA_W-1:0] done_result_q, done_result_d;

  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs_rdata, rt_rdata;
  decode_t           dec;

  regfile_32x32 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .rs_addr   (instr_rs),
    .rs_rdata  (rs_rdata),
    .rt_addr   (instr_rt),
    .rt_rdata  (rt_rdata),
    .dbg_addr  (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  assign dec = decode_funct(instr_funct);

  // Next-state, ALU drive, retire outputs and register-file write mux
  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    rd_d          = rd_q;
    ill_d         = ill_q;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    done_rd_d     = done_rd_q;
    done_result_d = done_result_q;
    rf_we         = 1'b0;
    rf_waddr      = init_addr;
    rf_wdata      = init_wdata;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          alu_a_d  = rs_rdata;
          alu_b_d  = rt_rdata;
          alu_op_d = dec.op;
          rd_d     = instr_rd;
          ill_d    = dec.illegal;
          state_d  = EXEC;
        end else if (init_we) begin
          // Preload only when no instruction is being accepted
          rf_we = 1'b1;
        end
      end
      EXEC: begin
        done_result_d = ill_q ? '0 : alu_out;
        done_rd_d     = rd_q;
        done_d        = 1'b1;
        illegal_d     = ill_q;
        state_d       = WB;
      end
      WB: begin
        rf_we    = ~ill_q;
        rf_waddr = done_rd_q;
        rf_wdata = done_result_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= A_NOP;
      rd_q          <= '0;
      ill_q         <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      done_rd_q     <= '0;
      done_result_q <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      rd_q          <= rd_d;
      ill_q         <= ill_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      done_rd_q     <= done_rd_d;
      done_result_q <= done_result_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign done_rd     = done_rd_q;
  assign done_result = done_result_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus random traffic against a transaction model.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  instr_funct;
  logic [4:0]  instr_rs, instr_rt, instr_rd;
  logic        init_we;
  logic [4:0]  init_addr;
  logic [31:0] init_wdata;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        done;
  logic [4:0]  done_rd;
  logic [31:0] done_result;
  logic        illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_funct (instr_funct),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .instr_rd    (instr_rd),
    .init_we     (init_we),
    .init_addr   (init_addr),
    .init_wdata  (init_wdata),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .done        (done),
    .done_rd     (done_rd),
    .done_result (done_result),
    .illegal     (illegal),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  // Stand-in for the external combinational ALU
  always_comb begin
    case (alu_op)
      5'd1:    alu_out = alu_a + alu_b;
      5'd2:    alu_out = alu_a - alu_b;
      5'd3:    alu_out = alu_a & alu_b;
      5'd4:    alu_out = alu_a | alu_b;
      5'd5:    alu_out = alu_a ^ alu_b;
      5'd6:    alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'h0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%08h expected 0x%08h", tag, edge_cnt, got, exp);
    end
  endtask

  // Transaction-level model: architectural registers plus the one instruction in flight
  logic [31:0] rf_m [32];
  int          since_acc;   // edges since the last acceptance (saturating)
  logic [4:0]  p_rd;
  logic [31:0] p_res;
  logic        p_ill;
  logic [31:0] e_a, e_b;
  logic [4:0]  e_op;

  function automatic void model_reset();
    foreach (rf_m[i]) rf_m[i] = 32'h0;
    since_acc = 100;
    p_rd = 5'd0; p_res = 32'h0; p_ill = 1'b0;
    e_a = 32'h0; e_b = 32'h0; e_op = 5'd0;
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : rf_m[a];
  endfunction

  // Instruction semantics straight from the funct field
  function automatic void ref_exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [4:0] op, output logic ill, output logic [31:0] res);
    ill = 1'b0;
    case (f)
      6'h20, 6'h21: begin op = 5'd1; res = a + b;     end
      6'h22, 6'h23: begin op = 5'd2; res = a - b;     end
      6'h24:        begin op = 5'd3; res = a & b;     end
      6'h25:        begin op = 5'd4; res = a | b;     end
      6'h26:        begin op = 5'd5; res = a ^ b;     end
      6'h27:        begin op = 5'd6; res = ~(a | b);  end
      default:      begin op = 5'd0; res = 32'h0; ill = 1'b1; end
    endcase
  endfunction

  // Advance one clock edge, update the model from the inputs seen at that edge, then check outputs
  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      model_reset();
    end else begin
      if (since_acc < 100) since_acc++;
      if (since_acc == 2 && !p_ill && p_rd != 5'd0) rf_m[p_rd] = p_res;
      if (since_acc >= 3) begin
        if (instr_valid) begin
          e_a = rd_m(instr_rs);
          e_b = rd_m(instr_rt);
          ref_exec(instr_funct, e_a, e_b, e_op, p_ill, p_res);
          p_rd = instr_rd;
          since_acc = 0;
        end else if (init_we && init_addr != 5'd0) begin
          rf_m[init_addr] = init_wdata;
        end
      end
    end
    #1;
    check("ready",   32'(instr_ready), 32'(since_acc >= 2));
    check("done",    32'(done),        32'(since_acc == 1));
    check("illegal", 32'(illegal),     32'(since_acc == 1 && p_ill));
    if (since_acc == 1) begin
      check("done_rd",     32'(done_rd), 32'(p_rd));
      check("done_result", done_result,  p_res);
    end
    check("alu_a",     alu_a,         e_a);
    check("alu_b",     alu_b,         e_b);
    check("alu_op",    32'(alu_op),   32'(e_op));
    check("dbg_rdata", dbg_rdata,     rd_m(dbg_raddr));
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    init_we = 1'b1; init_addr = a; init_wdata = d;
    tick();
    init_we = 1'b0;
  endtask

  // Issue one instruction, wait for its retire and writeback, check the retired result
  task automatic run_op(input string tag, input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] exp_res, input logic exp_ill);
    instr_funct = f; instr_rs = rs; instr_rt = rt; instr_rd = rd; instr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (since_acc == 0) break;
    end
    check({tag, "_accept"}, 32'(instr_ready), 32'h0);
    instr_valid = 1'b0;
    tick();
    check({tag, "_done"},    32'(done),    32'h1);
    check({tag, "_result"},  done_result,  exp_res);
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ftab [10];
    int e1;
    ftab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};

    model_reset();
    rst = 1'b1; instr_valid = 1'b0; instr_funct = 6'h0;
    instr_rs = 5'd0; instr_rt = 5'd0; instr_rd = 5'd0;
    init_we = 1'b0; init_addr = 5'd0; init_wdata = 32'h0; dbg_raddr = 5'd0;
    tick(); tick();
    #2 rst = 1'b0;

    // Reset state and a cleared register file
    check("rst_alu_op",      32'(alu_op),      32'h0);
    check("rst_done",        32'(done),        32'h0);
    check("rst_ready",       32'(instr_ready), 32'h1);
    check("rst_done_rd",     32'(done_rd),     32'h0);
    check("rst_done_result", done_result,      32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      tick();
      check("rst_rf_zero", dbg_rdata, 32'h0);
    end

    // ADD r3 = r1 + r2
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    run_op("add", 6'h20, 5'd1, 5'd2, 5'd3, 32'd8, 1'b0);
    check("add_alu_a",  alu_a,       32'd5);
    check("add_alu_b",  alu_b,       32'd3);
    check("add_alu_op", 32'(alu_op), 32'd1);
    dbg_raddr = 5'd3; #1;
    check("add_r3", dbg_rdata, 32'd8);

    // Op sweep
    preload(5'd1, 32'h0F0F);
    preload(5'd2, 32'h00FF);
    run_op("sub",     6'h22, 5'd1, 5'd2, 5'd10, 32'h0000_0E10, 1'b0);
    run_op("and",     6'h24, 5'd1, 5'd2, 5'd11, 32'h0000_000F, 1'b0);
    run_op("or",      6'h25, 5'd1, 5'd2, 5'd12, 32'h0000_0FFF, 1'b0);
    run_op("xor",     6'h26, 5'd1, 5'd2, 5'd13, 32'h0000_0FF0, 1'b0);
    run_op("nor",     6'h27, 5'd0, 5'd0, 5'd14, 32'hFFFF_FFFF, 1'b0);
    run_op("subwrap", 6'h23, 5'd0, 5'd1, 5'd15, 32'hFFFF_F0F1, 1'b0);

    // Destination r0 and an undecoded funct
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    run_op("add_r0", 6'h21, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0);
    dbg_raddr = 5'd0; #1;
    check("r0_zero", dbg_rdata, 32'h0);
    run_op("illegal", 6'h2A, 5'd1, 5'd2, 5'd7, 32'h0, 1'b1);
    check("illegal_op", 32'(alu_op), 32'h0);
    dbg_raddr = 5'd7; #1;
    check("illegal_r7", dbg_rdata, 32'h0);

    // Back-to-back dependent pair with valid held high and init_we asserted throughout
    instr_valid = 1'b1; instr_funct = 6'h20; instr_rs = 5'd1; instr_rt = 5'd2; instr_rd = 5'd3;
    init_we = 1'b1; init_addr = 5'd5; init_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (since_acc == 0) break;
    end
    e1 = edge_cnt;
    instr_funct = 6'h22; instr_rs = 5'd3; instr_rt = 5'd1; instr_rd = 5'd4;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (since_acc == 0) break;
    end
    check("b2b_gap", 32'(edge_cnt - e1), 32'd3);
    instr_valid = 1'b0; init_we = 1'b0;
    tick();
    check("b2b_result", done_result, 32'd3);
    tick();
    dbg_raddr = 5'd4; #1;
    check("b2b_r4", dbg_rdata, 32'd3);
    dbg_raddr = 5'd5; #1;
    check("b2b_r5_untouched", dbg_rdata, 32'h0);

    // Reset while an instruction is in EXEC
    instr_valid = 1'b1; instr_funct = 6'h20; instr_rs = 5'd1; instr_rt = 5'd2; instr_rd = 5'd9;
    dbg_raddr = 5'd9;
    tick();
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_done",  32'(done),        32'h0);
    check("midrst_op",    32'(alu_op),      32'h0);
    check("midrst_ready", 32'(instr_ready), 32'h1);
    tick();
    #2 rst = 1'b0;
    check("midrst_r9", dbg_rdata, 32'h0);
    instr_valid = 1'b1; instr_funct = 6'h27; instr_rs = 5'd0; instr_rt = 5'd0; instr_rd = 5'd1;
    tick();
    check("postrst_accept", 32'(instr_ready), 32'h0);
    check("postrst_op",     32'(alu_op),      32'd6);
    instr_valid = 1'b0;
    tick();
    check("postrst_nor", done_result, 32'hFFFF_FFFF);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      instr_valid = ($urandom_range(0, 1) == 1);
      instr_funct = ftab[$urandom_range(0, 9)];
      instr_rs    = 5'($urandom_range(0, 7));
      instr_rt    = 5'($urandom_range(0, 7));
      instr_rd    = 5'($urandom_range(0, 7));
      init_we     = ($urandom_range(0, 3) == 0);
      init_addr   = 5'($urandom_range(0, 7));
      init_wdata  = $urandom;
      dbg_raddr   = 5'($urandom_range(0, 31));
      tick();
    end
    instr_valid = 1'b0; init_we = 1'b0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback controller that drives the existing combinational ALU: it is the initiator on the alu_a/alu_b/alu_op/alu_out interface.
- Accepts MIPS R-type ALU instructions (funct, rs, rt, rd) over a valid/ready handshake.
- Reads operands from an internal 32x32 register file, presents them with the ALU op code, captures the result, and writes it back.
- Sits between instruction decode and the ALU in the single-issue datapath.

Parameters:
DATA_W, 32, operand/result width
NREGS, 32, register count; address width is log2(NREGS) = 5

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept; transfer on valid&ready at a clk edge
instr_funct  in  6  MIPS funct field
instr_rs  in  5  source A register
instr_rt  in  5  source B register
instr_rd  in  5  destination register
init_we  in  1  preload write enable; honoured only in IDLE with no handshake that cycle
init_addr  in  5  preload address
init_wdata  in  32  preload data
alu_a  out  32  ALU operand A (registered)
alu_b  out  32  ALU operand B (registered)
alu_op  out  5  ALU op code (registered)
alu_out  in  32  ALU result (combinational from alu_a/alu_b/alu_op)
done  out  1  one-cycle pulse: instruction retired
done_rd  out  5  destination of retired instruction, valid with done
done_result  out  32  result of retired instruction, valid with done; 0 when illegal
illegal  out  1  one-cycle pulse with done when funct is undecoded
dbg_raddr  in  5  debug read address
dbg_rdata  out  32  combinational register file read; reads 0 for address 0

Behaviour:
- Reset: state=IDLE; alu_a=0, alu_b=0, alu_op=0 (NOP); done=0, illegal=0, done_rd=0, done_result=0; all registers cleared. Transfers and init writes are ignored while rst is high.
- Op codes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6.
- Decode map: funct 0x20/0x21 -> ADD; 0x22/0x23 -> SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
- Any other funct -> NOP and illegal.
- instr_ready = (state==IDLE), combinational from state.
- FSM:
  - IDLE: on valid&ready at edge N:
    - alu_a <= rf[rs], alu_b <= rf[rt], alu_op <= decoded op.
    - Latch rd and the illegal flag; go to EXEC.
  - EXEC: at edge N+1, result_q <= alu_out (illegal: 0); go to WB.
  - WB (cycle N+1..N+2): done=1, illegal per flag, done_rd=latched rd, done_result=result_q.
    - At edge N+2: rf[rd] <= result_q if legal and rd!=0; go to IDLE.
- Latency: done is visible one cycle after acceptance. Throughput is one instruction per 3 cycles; the next acceptance is at the earliest edge N+3.
- Hazards: writeback completes before the next operand read, so dependent back-to-back instructions see the new value. No bypass is needed.
- Register 0: writes are discarded; reads return 0 on every read port.
- Arithmetic: 32-bit two's complement, wrap-around, no overflow trap (ADD and ADDU are identical).
- alu_a/alu_b/alu_op hold their values outside IDLE-accept edges; after retire, alu_op keeps the last op.
- init_we: writes rf[init_addr] at the edge if the state is IDLE and there is no simultaneous handshake. The handshake wins; init_we is dropped in any other state.
- Reset mid-operation: returns to IDLE immediately; the in-flight instruction is dropped with no done pulse and no writeback.

Decomposition:
- Package alu_pkg:
  - A_NOP..A_NOR op codes.
  - Funct constants F_ADD..F_NOR.
  - FSM state encoding IDLE/EXEC/WB.
  - DATA_W default.
- Sub-module regfile_32x32:
  - Reads: three combinational read ports (rs, rt, dbg).
  - Writes: one synchronous write port, muxed between writeback and init.
  - Behaviour: async active-high reset clears it; r0 hardwired to 0.

Test Plan:
- Reset: assert rst mid-run -> alu_op=0, done=0, instr_ready=1 after release; dbg_rdata=0 for all 32 addresses.
- ADD: preload r1=5, r2=3; funct 0x20 rs=1 rt=2 rd=3.
  - Cycle after accept: alu_a=5, alu_b=3, alu_op=1.
  - Next cycle: done=1, done_rd=3, done_result=8.
  - Then dbg r3=8.
- Op sweep with r1=0x0F0F, r2=0x00FF:
  - SUB -> 0x0E10; AND -> 0x000F; OR -> 0x0FFF; XOR -> 0x0FF0.
  - NOR r0,r0 -> 0xFFFFFFFF; SUB r0-r1 -> 0xFFFFF0F1 (wrap).
- rd=0 and illegal:
  - ADD to r0 -> done_result=8, r0 still reads 0.
  - funct 0x2A -> alu_op=0, done=1 with illegal=1, done_result=0, no register changes.
- Back-to-back dependent, instr_valid held high:
  - Sequence: r3=r1+r2, then r4=r3-r1 with r1=5, r2=3.
  - Second accepted exactly 3 cycles after the first; r4=3.
  - init_we during EXEC is ignored.
- Async reset asserted during EXEC:
  - No done pulse; the destination register is not written and reads 0 after reset.
  - The state is IDLE on the first edge after release.
